// File: rtl/sort_sequencer.sv
// sort_sequencer
//   Controller for the bubble-sort datapath. Collects N unsigned entries over a
//   valid/ready load port, sorts them in place with one compare-and-swap step
//   per clock, then streams the ascending result out over a valid/ready port
//   with a last marker.
//
//   Optional build macro: SORT_EARLY_EXIT_EN
//     When defined, a pass that performs no swaps ends the sort immediately.
//     Output data and swap_cnt are unchanged; only the SORT latency differs.
//
// Parameters
//   N  entries per batch (2..16)
//   W  entry width in bits (unsigned)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   load entry present
//   in_data    load entry value
//   in_ready   load accepted (IDLE only)
//   start      begin sorting (honoured in FULL only)
//   busy       high while sorting or streaming out
//   done       one-cycle pulse after the final output transfer
//   out_valid  sorted entry present
//   out_data   sorted entry value
//   out_last   marks entry index N-1
//   out_ready  downstream accepts the entry
//   swap_cnt   swaps made by the most recent sort
module sort_sequencer #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic [7:0]   swap_cnt
);

    localparam int unsigned IW = (N > 2) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
    localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FULL = 2'd1,
        SORT = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [W-1:0]  entry [N];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] step;
    logic [IW-1:0] step_p1;
    logic [IW-1:0] pass;
    logic [7:0]    swap_cnt_q;
    logic          done_q;

`ifdef SORT_EARLY_EXIT_EN
    logic          pass_swapped;
`endif

    logic [W-1:0]  cmp_lo;
    logic [W-1:0]  cmp_hi;
    logic          do_swap;
    logic          pass_end;
    logic          sort_end;
    logic          load_fire;
    logic          out_fire;
    logic          out_final;

    // ------------------------------------------------------------------
    // Compare-and-swap datapath and sequencing decisions
    // ------------------------------------------------------------------
    always_comb begin
        step_p1   = step + IW'(1);
        cmp_lo    = entry[step];
        cmp_hi    = entry[step_p1];
        // strict greater-than keeps equal keys in their original order
        do_swap   = (state == SORT) && (cmp_lo > cmp_hi);
        // each pass covers one fewer pair than the last
        pass_end  = (step == (LAST_PASS - pass));
`ifdef SORT_EARLY_EXIT_EN
        sort_end  = pass_end && ((pass == LAST_PASS) || !(pass_swapped || do_swap));
`else
        sort_end  = pass_end && (pass == LAST_PASS);
`endif
        load_fire = (state == IDLE) && in_valid;
        out_fire  = (state == OUT) && out_ready;
        out_final = out_fire && (rd_idx == LAST_IDX);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (load_fire && (wr_idx == LAST_IDX)) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (start) begin
                    state_nxt = SORT;
                end
            end
            SORT: begin
                busy = 1'b1;
                if (sort_end) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = entry[rd_idx];
                out_last  = (rd_idx == LAST_IDX);
                if (out_final) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, swap tally and done pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx       <= '0;
            rd_idx       <= '0;
            step         <= '0;
            pass         <= '0;
            swap_cnt_q   <= '0;
            done_q       <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
            pass_swapped <= 1'b0;
`endif
        end else begin
            done_q <= out_final;
            unique case (state)
                IDLE: begin
                    if (load_fire) begin
                        wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IW'(1);
                    end
                end
                FULL: begin
                    if (start) begin
                        swap_cnt_q   <= '0;
                        pass         <= '0;
                        step         <= '0;
`ifdef SORT_EARLY_EXIT_EN
                        pass_swapped <= 1'b0;
`endif
                    end
                end
                SORT: begin
                    if (do_swap) begin
                        swap_cnt_q <= swap_cnt_q + 8'd1;
                    end
                    if (pass_end) begin
                        step <= '0;
                        pass <= pass + IW'(1);
`ifdef SORT_EARLY_EXIT_EN
                        pass_swapped <= 1'b0;
`endif
                        if (sort_end) begin
                            rd_idx <= '0;
                        end
                    end else begin
                        step <= step_p1;
`ifdef SORT_EARLY_EXIT_EN
                        pass_swapped <= pass_swapped | do_swap;
`endif
                    end
                end
                OUT: begin
                    if (out_fire) begin
                        rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry storage: load writes in IDLE, in-place swaps in SORT
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (load_fire) begin
                entry[wr_idx] <= in_data;
            end else if (do_swap) begin
                entry[step]    <= cmp_hi;
                entry[step_p1] <= cmp_lo;
            end
        end
    end

    assign done     = done_q;
    assign swap_cnt = swap_cnt_q;

endmodule

// File: tb/tb_sort_sequencer.sv
module tb_sort_sequencer;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4;

`ifdef SORT_EARLY_EXIT_EN
    localparam int SORTED_CYCLES = 3;
`else
    localparam int SORTED_CYCLES = 6;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         start;
    logic         busy;
    logic         done;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_ready;
    logic [7:0]   swap_cnt;

    int total;
    int bad;

    sort_sequencer #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .swap_cnt  (swap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All helpers are entered and left at a falling edge.
    // vals holds entry i in bits [4i+3:4i].
    task automatic load_vals(input logic [15:0] vals, input int cnt, input bit start_on_last);
        for (int i = 0; i < cnt; i++) begin
            in_valid = 1'b1;
            in_data  = vals[4*i +: 4];
            start    = start_on_last && (i == cnt - 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at the first SORT cycle; left at the falling edge after the
    // final output transfer (where done must be high).
    task automatic collect(input logic [7:0] pat, output int sort_cycles,
                           output logic [15:0] outs, output logic [3:0] last_mask,
                           output int stall_changes, output int n_out,
                           output logic done_seen);
        int cyc;
        logic prev_stall;
        logic [W-1:0] prev_data;
        sort_cycles   = 0;
        outs          = '0;
        last_mask     = '0;
        stall_changes = 0;
        n_out         = 0;
        cyc           = 0;
        prev_stall    = 1'b0;
        prev_data     = '0;
        while (busy && !out_valid && sort_cycles < 200) begin
            sort_cycles++;
            @(negedge clk);
        end
        while (n_out < 4 && cyc < 200) begin
            out_ready = (cyc < 8) ? pat[cyc] : 1'b1;
            if (prev_stall && out_data !== prev_data) stall_changes++;
            if (out_valid && out_ready) begin
                outs[4*n_out +: 4] = out_data;
                last_mask[n_out]   = out_last;
                n_out++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        done_seen = done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin bad++; $display("FAIL reset_out got=%b%b want=00", out_valid, out_last); end
        total++; if (out_data !== 4'd0) begin bad++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
        total++; if (swap_cnt !== 8'd0) begin bad++; $display("FAIL reset_swap_cnt got=%0d want=0", swap_cnt); end
    endtask

    // Generic directed batch: load, start, collect with out_ready=1
    task automatic run_batch(input string name, input logic [15:0] vals, input logic [15:0] exp_outs,
                             input int exp_swaps, input int exp_cycles);
        int sc, so, no;
        logic [15:0] outs;
        logic [3:0] lm;
        logic dn;
        load_vals(vals, 4, 1'b0);
        total++; if (in_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s_full got in_ready=%b busy=%b want 0 0", name, in_ready, busy); end
        do_start();
        collect(8'hFF, sc, outs, lm, so, no, dn);
        total++; if (sc !== exp_cycles) begin bad++; $display("FAIL %s_sort_cycles got=%0d want=%0d", name, sc, exp_cycles); end
        total++; if (outs !== exp_outs) begin bad++; $display("FAIL %s_outs got=%h want=%h", name, outs, exp_outs); end
        total++; if (lm !== 4'b1000) begin bad++; $display("FAIL %s_last got=%b want=1000", name, lm); end
        total++; if (swap_cnt !== exp_swaps[7:0]) begin bad++; $display("FAIL %s_swap_cnt got=%0d want=%0d", name, swap_cnt, exp_swaps); end
        total++; if (dn !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL %s_done got done=%b in_ready=%b busy=%b want 1 1 0", name, dn, in_ready, busy); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done_width got=%b want=0", name, done); end
        total++; if (swap_cnt !== exp_swaps[7:0]) begin bad++; $display("FAIL %s_swap_hold got=%0d want=%0d", name, swap_cnt, exp_swaps); end
    endtask

    task automatic test_basic();
        // 9,3,12,3 -> 3,3,9,12 ; swaps (9,3) (12,3) (9,3)
        run_batch("basic", {4'd3, 4'd12, 4'd3, 4'd9}, {4'd12, 4'd9, 4'd3, 4'd3}, 3, 6);
    endtask

    task automatic test_reverse();
        run_batch("reverse", {4'd0, 4'd5, 4'd10, 4'd15}, {4'd15, 4'd10, 4'd5, 4'd0}, 6, 6);
    endtask

    task automatic test_sorted();
        run_batch("sorted", {4'd4, 4'd3, 4'd2, 4'd1}, {4'd4, 4'd3, 4'd2, 4'd1}, 0, SORTED_CYCLES);
    endtask

    task automatic test_backpressure();
        int sc, so, no;
        logic [15:0] outs;
        logic [3:0] lm;
        logic dn;
        // 5,14,0,9 -> 0,5,9,14 ; ready pattern 0,0,1,0,1,1,0,1
        load_vals({4'd9, 4'd0, 4'd14, 4'd5}, 4, 1'b0);
        do_start();
        collect(8'b1011_0100, sc, outs, lm, so, no, dn);
        total++; if (no !== 4) begin bad++; $display("FAIL bp_count got=%0d want=4", no); end
        total++; if (outs !== {4'd14, 4'd9, 4'd5, 4'd0}) begin bad++; $display("FAIL bp_outs got=%h want=e950", outs); end
        total++; if (so !== 0) begin bad++; $display("FAIL bp_stable got=%0d changes want=0", so); end
        total++; if (lm !== 4'b1000) begin bad++; $display("FAIL bp_last got=%b want=1000", lm); end
        total++; if (swap_cnt !== 8'd3) begin bad++; $display("FAIL bp_swap_cnt got=%0d want=3", swap_cnt); end
        total++; if (dn !== 1'b1) begin bad++; $display("FAIL bp_done got=%b want=1", dn); end
        @(negedge clk);
    endtask

    task automatic test_protocol();
        int sc, so, no;
        logic [15:0] outs;
        logic [3:0] lm;
        logic dn;
        // three loads then start: must stay in IDLE
        load_vals({4'd0, 4'd9, 4'd4, 4'd6}, 3, 1'b0);
        do_start();
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL proto_early_start got in_ready=%b busy=%b want 1 0", in_ready, busy); end
        load_vals({12'd0, 4'd2}, 1, 1'b0);
        total++; if (in_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL proto_full got in_ready=%b busy=%b want 0 0", in_ready, busy); end
        do_start();
        // loads during SORT must be refused
        in_valid = 1'b1;
        in_data  = 4'd0;
        total++; if (in_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL proto_sort_load got in_ready=%b busy=%b want 0 1", in_ready, busy); end
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        collect(8'hFF, sc, outs, lm, so, no, dn);
        total++; if (outs !== {4'd9, 4'd6, 4'd4, 4'd2}) begin bad++; $display("FAIL proto_outs got=%h want=9642", outs); end
        @(negedge clk);
        // start held with the 4th write: ignored, batch stays FULL
        load_vals({4'd0, 4'd1, 4'd8, 4'd8}, 4, 1'b1);
        @(negedge clk);
        total++; if (busy !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL proto_start_with_load got busy=%b in_ready=%b want 0 0", busy, in_ready); end
        do_start();
        collect(8'hFF, sc, outs, lm, so, no, dn);
        total++; if (outs !== {4'd8, 4'd8, 4'd1, 4'd0}) begin bad++; $display("FAIL proto_resort_outs got=%h want=8810", outs); end
        total++; if (swap_cnt !== 8'd5) begin bad++; $display("FAIL proto_resort_swaps got=%0d want=5", swap_cnt); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int sc, so, no;
        logic [15:0] outs;
        logic [3:0] lm;
        logic dn;
        load_vals({4'd1, 4'd2, 4'd3, 4'd4}, 4, 1'b0);
        do_start();
        collect(8'hFF, sc, outs, lm, so, no, dn);
        total++; if (dn !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_done_ready got done=%b in_ready=%b want 1 1", dn, in_ready); end
        // load starts on the done cycle
        load_vals({4'd11, 4'd6, 4'd13, 4'd6}, 4, 1'b0);
        do_start();
        collect(8'hFF, sc, outs, lm, so, no, dn);
        total++; if (outs !== {4'd13, 4'd11, 4'd6, 4'd6}) begin bad++; $display("FAIL b2b_outs got=%h want=db66", outs); end
        total++; if (swap_cnt !== 8'd2) begin bad++; $display("FAIL b2b_swaps got=%0d want=2", swap_cnt); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sort();
        int sc, so, no;
        logic [15:0] outs;
        logic [3:0] lm;
        logic dn;
        load_vals({4'd3, 4'd12, 4'd3, 4'd9}, 4, 1'b0);
        do_start();
        @(negedge clk);
        @(negedge clk);
        // two compares done; first one swapped
        total++; if (swap_cnt !== 8'd1 || busy !== 1'b1) begin bad++; $display("FAIL rst_pre got swap_cnt=%0d busy=%b want 1 1", swap_cnt, busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_state got in_ready=%b busy=%b out_valid=%b want 1 0 0", in_ready, busy, out_valid); end
        total++; if (swap_cnt !== 8'd0 || done !== 1'b0) begin bad++; $display("FAIL rst_mid_cnt got swap_cnt=%0d done=%b want 0 0", swap_cnt, done); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_nodone got=%b want=0", done); end
        run_batch("after_rst", {4'd1, 4'd8, 4'd2, 4'd7}, {4'd8, 4'd7, 4'd2, 4'd1}, 4, 6);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        start     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_reverse();
        test_sorted();
        test_backpressure();
        test_protocol();
        test_back_to_back();
        test_reset_mid_sort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
